fetch_path: RTL and testbench

- Instruction-fetch stage of the pipelined MIPS core.
- Owns the PC register and issues in-order requests to instruction memory over a valid/ready request channel with a fixed-order response channel.
- Buffers returned words in a small in-order buffer and drives the IF/ID register (inst_D, pc_plus4_D).
- Consumes the branch/jump redirect that decode resolves early, squashing the wrong-path instruction and discarding stale in-flight responses.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_buffer.sv | 65 ++++++
 rtl/fetch_path.sv | 116 +++++++++++
 tb/tb_fetch_path.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch stage.
// Entry layout used by the in-order fetch buffer.
package fetch_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc_plus4;
    logic [31:0] inst;
    logic        filled;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: circular allocate/fill/pop buffer for fetch.
// Entries are allocated at issue and filled in response order.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     alloc,
  input  logic [31:0]              alloc_pc_plus4,
  input  logic                     fill,
  input  logic [31:0]              fill_inst,
  input  logic                     pop,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   unfilled
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] head_ptr;
  logic [AW-1:0] tail_ptr;
  logic [AW-1:0] fill_ptr;

  assign head = mem[head_ptr];

  // pointers and occupancy; flush drops every entry at once
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      fill_ptr <= '0;
      count    <= '0;
      unfilled <= '0;
    end else begin
      if (alloc) tail_ptr <= tail_ptr + AW'(1);
      if (fill)  fill_ptr <= fill_ptr + AW'(1);
      if (pop)   head_ptr <= head_ptr + AW'(1);
      count    <= count + CW'(alloc) - CW'(pop);
      unfilled <= unfilled + CW'(alloc) - CW'(fill);
    end
  end

  // entry storage; alloc and fill never hit the same slot
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int i = 0; i < DEPTH; i++) mem[i].filled <= 1'b0;
    end else begin
      if (alloc) begin
        mem[tail_ptr] <= '{pc_plus4: alloc_pc_plus4,
                           inst:     NOP_INST,
                           filled:   1'b0};
      end
      if (fill) begin
        mem[fill_ptr].inst   <= fill_inst;
        mem[fill_ptr].filled <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_path.sv
// fetch_path: PC, imem request issue, stale-response drop
// and the IF/ID register of the pipelined MIPS core.
module fetch_path
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_D,
  input  logic        pc_src_D,
  input  logic [31:0] pc_br_D,
  input  logic        jump_D,
  input  logic [31:0] pc_jmp_D,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] inst_D,
  output logic [31:0] pc_plus4_D,
  output logic        valid_D
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = CW + 1;
  localparam logic [OW-1:0] LIMIT = OW'(DEPTH);

  logic [31:0]   pc_F;
  logic [31:0]   target;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] count;
  logic [CW-1:0] unfilled;
  logic [OW-1:0] occupancy;
  fetch_entry_t  head;
  logic          redirect;
  logic          alloc;
  logic          dropping;
  logic          rsp_ok;
  logic          fill;
  logic          head_ready;
  logic          pop;

  assign redirect  = valid_D & ~stall_D & (jump_D | pc_src_D);
  assign target    = jump_D ? pc_jmp_D : pc_br_D;
  assign occupancy = OW'(count) + OW'(drop_cnt);

  assign imem_req_valid = ~reset & ~redirect & (occupancy < LIMIT);
  assign imem_req_addr  = pc_F;
  assign alloc          = imem_req_valid & imem_req_ready;

  // a response with nothing outstanding is ignored
  assign dropping = drop_cnt != '0;
  assign rsp_ok   = imem_rsp_valid & (dropping | (unfilled != '0));
  assign fill     = rsp_ok & ~dropping;

  // an unfilled head is always the fill target, so bypass it
  assign head_ready = (count != '0) & (head.filled | fill);
  assign pop        = ~reset & ~redirect & ~stall_D & head_ready;

  fetch_buffer #(
    .DEPTH (DEPTH)
  ) u_buf (
    .clk            (clk),
    .reset          (reset),
    .flush          (redirect),
    .alloc          (alloc),
    .alloc_pc_plus4 (pc_F + 32'd4),
    .fill           (fill),
    .fill_inst      (imem_rsp_data),
    .pop            (pop),
    .head           (head),
    .count          (count),
    .unfilled       (unfilled)
  );

  // program counter: redirect beats sequential advance
  always_ff @(posedge clk) begin
    if (reset)         pc_F <= RESET_PC;
    else if (redirect) pc_F <= target;
    else if (alloc)    pc_F <= pc_F + 32'd4;
  end

  // credits for wrong-path responses still in flight
  always_ff @(posedge clk) begin
    if (reset)
      drop_cnt <= '0;
    else if (redirect)
      drop_cnt <= drop_cnt + unfilled - CW'(rsp_ok);
    else if (imem_rsp_valid & dropping)
      drop_cnt <= drop_cnt - CW'(1);
  end

  // IF/ID register: squash, hold, load or bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_D     <= NOP_INST;
      pc_plus4_D <= '0;
      valid_D    <= 1'b0;
    end else if (redirect) begin
      inst_D  <= NOP_INST;
      valid_D <= 1'b0;
    end else if (!stall_D) begin
      if (head_ready) begin
        inst_D     <= head.filled ? head.inst : imem_rsp_data;
        pc_plus4_D <= head.pc_plus4;
        valid_D    <= 1'b1;
      end else begin
        inst_D  <= NOP_INST;
        valid_D <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_path.sv
// tb_fetch_path: directed vectors for fetch_path against an
// in-order memory model whose word is the inverted address.
module tb_fetch_path;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_D;
  logic        pc_src_D;
  logic [31:0] pc_br_D;
  logic        jump_D;
  logic [31:0] pc_jmp_D;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] inst_D;
  logic [31:0] pc_plus4_D;
  logic        valid_D;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        pend[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_inst[$];
  logic [31:0] exp_pc[$];
  int          cyc;
  int          lat;
  int          max_if;
  int          nvec;
  int          nerr;

  always #5 clk = ~clk;

  fetch_path dut (
    .clk            (clk),
    .reset          (reset),
    .stall_D        (stall_D),
    .pc_src_D       (pc_src_D),
    .pc_br_D        (pc_br_D),
    .jump_D         (jump_D),
    .pc_jmp_D       (pc_jmp_D),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_D         (inst_D),
    .pc_plus4_D     (pc_plus4_D),
    .valid_D        (valid_D)
  );

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    int due;
    int inflight;
    #1;
    if (!reset && valid_D && !stall_D) begin
      got_pc.push_back(pc_plus4_D);
      got_inst.push_back(inst_D);
    end
    if (!reset && imem_req_valid && imem_req_ready) begin
      due = cyc + lat;
      if (pend.size() > 0 && due <= pend[$].due) due = pend[$].due + 1;
      pend.push_back('{addr: imem_req_addr, due: due});
    end
    inflight = pend.size() + int'(imem_rsp_valid);
    if (inflight > max_if) max_if = inflight;
    @(posedge clk);
    #1;
    cyc++;
    if (reset) pend.delete();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = ~pend[0].addr;
      void'(pend.pop_front());
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    got_pc.delete();
    got_inst.delete();
    max_if = 0;
  endtask

  task automatic wait_pc(logic [31:0] t);
    for (int i = 0; i < 40; i++) begin
      if (valid_D && pc_plus4_D == t) break;
      tick();
    end
    check("reach_pc", pc_plus4_D, t);
  endtask

  task automatic collect();
    int n;
    n = exp_pc.size();
    for (int i = 0; i < 80 && got_pc.size() < n; i++) tick();
    check("retired_count", got_pc.size(), n);
    for (int i = 0; i < n && i < got_pc.size(); i++) begin
      check("pc_plus4", got_pc[i], exp_pc[i]);
      check("inst", got_inst[i], ~(exp_pc[i] - 32'd4));
    end
  endtask

  initial begin
    reset          = 1'b1;
    stall_D        = 1'b0;
    pc_src_D       = 1'b0;
    jump_D         = 1'b0;
    pc_br_D        = '0;
    pc_jmp_D       = '0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    cyc = 0; lat = 1; max_if = 0; nvec = 0; nerr = 0;

    // reset values and straight-line warm-up, latency 1
    tick();
    tick();
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_valid_D", valid_D, 0);
    check("rst_inst_D", inst_D, 0);
    check("rst_pc4_D", pc_plus4_D, 0);
    reset = 1'b0;
    #1;
    check("req0_valid", imem_req_valid, 1);
    check("req0_addr", imem_req_addr, 32'h0);
    tick();
    check("req1_addr", imem_req_addr, 32'h4);
    check("warm_valid_D", valid_D, 0);
    tick();
    check("first_valid_D", valid_D, 1);
    check("first_pc4", pc_plus4_D, 32'h4);
    check("first_inst", inst_D, 32'hFFFF_FFFF);
    check("req2_addr", imem_req_addr, 32'h8);
    tick();
    check("seq_valid_1", valid_D, 1);
    check("seq_pc4_1", pc_plus4_D, 32'h8);
    tick();
    check("seq_valid_2", valid_D, 1);
    check("seq_pc4_2", pc_plus4_D, 32'hC);
    exp_pc = '{32'h4, 32'h8, 32'hC, 32'h10};
    collect();

    // taken branch with a stale word still in flight
    lat = 2;
    do_reset();
    wait_pc(32'h8);
    pc_src_D = 1'b1;
    pc_br_D  = 32'h100;
    #1;
    check("br_no_issue", imem_req_valid, 0);
    tick();
    pc_src_D = 1'b0;
    #1;
    check("br_squash_valid", valid_D, 0);
    check("br_squash_inst", inst_D, 0);
    check("br_hold_pc4", pc_plus4_D, 32'h8);
    check("br_target_valid", imem_req_valid, 1);
    check("br_target_addr", imem_req_addr, 32'h100);
    exp_pc = '{32'h4, 32'h8, 32'h104, 32'h108};
    collect();

    // jump beats branch, then a jump that wraps the PC
    lat = 1;
    do_reset();
    wait_pc(32'h8);
    jump_D   = 1'b1;
    pc_src_D = 1'b1;
    pc_jmp_D = 32'h200;
    pc_br_D  = 32'h100;
    tick();
    jump_D   = 1'b0;
    pc_src_D = 1'b0;
    #1;
    check("jmp_target_addr", imem_req_addr, 32'h200);
    wait_pc(32'h208);
    jump_D   = 1'b1;
    pc_jmp_D = 32'hFFFF_FFF8;
    tick();
    jump_D = 1'b0;
    exp_pc = '{32'h4, 32'h8, 32'h204, 32'h208,
               32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8};
    collect();

    // branch held off by a two-cycle stall
    do_reset();
    wait_pc(32'hC);
    pc_src_D = 1'b1;
    pc_br_D  = 32'h300;
    stall_D  = 1'b1;
    tick();
    check("stall1_valid", valid_D, 1);
    check("stall1_pc4", pc_plus4_D, 32'hC);
    tick();
    check("stall2_valid", valid_D, 1);
    check("stall2_inst", inst_D, ~32'h8);
    stall_D = 1'b0;
    tick();
    pc_src_D = 1'b0;
    #1;
    check("stall_br_valid", valid_D, 0);
    check("stall_br_addr", imem_req_addr, 32'h300);
    exp_pc = '{32'h4, 32'h8, 32'hC, 32'h304, 32'h308};
    collect();

    // memory not ready for 5 cycles, then latency 3
    lat = 3;
    imem_req_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      #1;
      check("nordy_valid", imem_req_valid, 1);
      check("nordy_addr", imem_req_addr, 32'h0);
      tick();
    end
    imem_req_ready = 1'b1;
    exp_pc = '{32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18};
    collect();
    check("max_inflight_ok", max_if <= 2, 1);

    // reset with two requests outstanding
    for (int i = 0; i < 20 && pend.size() < 2; i++) tick();
    check("pend_two", pend.size(), 2);
    reset = 1'b1;
    #1;
    check("mid_rst_req", imem_req_valid, 0);
    tick();
    check("mid_rst_valid_D", valid_D, 0);
    check("mid_rst_inst_D", inst_D, 0);
    check("mid_rst_pc4_D", pc_plus4_D, 0);
    reset = 1'b0;
    #1;
    check("post_rst_valid", imem_req_valid, 1);
    check("post_rst_addr", imem_req_addr, 32'h0);
    got_pc.delete();
    got_inst.delete();
    exp_pc = '{32'h4, 32'h8, 32'hC};
    collect();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
